clock_set_controller: RTL
=========================

// Module: clock_set_controller
// PURPOSE
//   Mode/set sequencer for the 8-digit 7-seg clock. Debounces KEY1..KEY3 and the set switch.
//   Runs a RUN/SET field FSM and issues one-cycle inc/dec pulses plus a field select to the
//   time counters. Gates the counter run-enable and drives a per-digit blink/blank mask.
// PARAMETERS
//   DEBOUNCE_CYCLES      500000  consecutive stable samples before a key/switch level is accepted (10 ms @50 MHz)
//   BLINK_HALF_CYCLES    12500000 half-period of selected-field blink (250 ms)
//   REPEAT_DELAY_CYCLES  25000000 hold time before first auto-repeat (AUTO_REPEAT_EN only)
//   REPEAT_PERIOD_CYCLES 5000000  auto-repeat interval (AUTO_REPEAT_EN only)
// PORTS
//   clk_50mhz_i             in  1  system clock, 50 MHz
//   master_nreset_switch_i  in  1  async active-low reset
//   key1_i                  in  1  raw key, active-low: next field
//   key2_i                  in  1  raw key, active-low: increment
//   key3_i                  in  1  raw key, active-low: decrement
//   set_switch_i            in  1  raw switch, 1 = set mode
//   run_en_o                out 1  time counters advance when 1
//   set_mode_o              out 1  1 while in any SET state
//   field_sel_o             out 2  FIELD_NONE/HR/MIN/SEC (pkg encoding 0/1/2/3)
//   inc_pulse_o             out 1  one-cycle increment of field_sel_o field
//   dec_pulse_o             out 1  one-cycle decrement of field_sel_o field
//   clear_sub_o             out 1  one-cycle clear of centi/deci-second digits
//   blank_mask_o            out 8  1 = blank digit; bit0 centisec .. bit7 decahr
// BEHAVIOUR
//   - Clock clk_50mhz_i only; reset async active-low; all outputs registered.
//   - Reset: state RUN, run_en_o=1, set_mode_o=0, field_sel_o=NONE, pulses=0, blank_mask_o=0.
//     Debounced keys reset to released; debounced switch resets to 0.
//   - Inputs: 2-flop synchronizer, then debouncer. The accepted level updates after
//     DEBOUNCE_CYCLES identical samples; the counter restarts on any change.
//   - Press event: debounced key 1->0 transition, one cycle wide.
//     Latency from raw edge to pulse output: 2 + DEBOUNCE_CYCLES + 1 cycles.
//   - FSM: RUN, SET_HR, SET_MIN, SET_SEC.
//     RUN & switch=1 -> SET_HR. Any SET & switch=0 -> RUN, with clear_sub_o=1 on the transition cycle.
//     SET & key1 press: HR->MIN->SEC->HR.
//   - Outputs per state:
//     RUN: run_en_o=1, field NONE, key presses ignored.
//     SET_*: run_en_o=0, set_mode_o=1, field_sel_o = current field.
//   - In SET: key2 press -> inc_pulse_o; key3 press -> dec_pulse_o. Pulses carry the field
//     valid on that cycle. Counters own wrap-around (23->0, 59->0, 0->max).
//   - Simultaneous events (same cycle):
//     key2+key3: no pulse.
//     key1 with key2/key3: field advance only, inc/dec dropped.
//     switch falling with any key: exit wins, no pulses.
//   - Blink: free-running phase toggles every BLINK_HALF_CYCLES. Phase resets to visible (0) on
//     SET entry, field change and each inc/dec. phase=1 blanks the selected field:
//     HR 0xC0, MIN 0x30, SEC 0x0C. RUN: blank_mask_o=0.
//   - Reset mid-operation: immediate return to reset values; no clear_sub_o emitted.
// CONFIGURATION
//   - AUTO_REPEAT_EN defined: holding exactly one of key2/key3 in SET repeats its pulse.
//     First repeat comes REPEAT_DELAY_CYCLES after the press pulse, then every REPEAT_PERIOD_CYCLES.
//     Repeat stops on release, field change or SET exit. Each repeat resets the blink phase.
//   - AUTO_REPEAT_EN undefined: exactly one pulse per press; the REPEAT_* parameters are unused.
// STRUCTURE
//   - Package clock_ctrl_pkg: state enum (RUN, SET_HR, SET_MIN, SET_SEC), FIELD_* codes,
//     MASK_HR/MIN/SEC constants.
//   - Sub-module key_debouncer (sync + debounce + press pulse, param DEBOUNCE_CYCLES),
//     instanced 4x (switch uses its level).
// TESTING  (bench: DEBOUNCE_CYCLES=4, BLINK_HALF_CYCLES=8, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=5)
//   - Reset during SET_MIN with phase=1 -> same cycle: run_en_o=1, field 0, blank_mask_o=0x00;
//     no clear_sub_o.
//   - SET_HR, key2 bounces 5x (2-cycle toggles) then held low -> exactly one inc_pulse_o,
//     field_sel_o=1, 7 cycles after the last edge.
//   - Switch=1 then key1 x3 -> field 1,2,3,1. blank_mask_o alternates 0x00/0xC0, then 0x30,
//     then 0x0C, every 8 cycles, visible first after each change.
//   - key2+key3 same cycle -> no pulse; key1+key3 same cycle -> field advance, no dec_pulse_o.
//   - Switch 1->0 -> exactly one clear_sub_o, run_en_o=1, blank_mask_o=0; later key2 -> no pulse.
//   - Hold key2 60 cycles in SET_SEC: AUTO_REPEAT_EN -> pulses at t0, t0+20, +25, +30 .. until
//     release; without the macro -> single pulse at t0.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the 7-seg clock mode/set sequencer.
// State encoding doubles as the field code so field_of() is a straight decode.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HR   = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam logic [7:0] MASK_HR  = 8'hC0;
    localparam logic [7:0] MASK_MIN = 8'h30;
    localparam logic [7:0] MASK_SEC = 8'h0C;

    function automatic logic [1:0] field_of(input state_e s);
        logic [1:0] f;
        case (s)
            ST_SET_HR:  f = FIELD_HR;
            ST_SET_MIN: f = FIELD_MIN;
            ST_SET_SEC: f = FIELD_SEC;
            default:    f = FIELD_NONE;
        endcase
        return f;
    endfunction

    function automatic state_e next_field(input state_e s);
        state_e n;
        case (s)
            ST_SET_HR:  n = ST_SET_MIN;
            ST_SET_MIN: n = ST_SET_SEC;
            ST_SET_SEC: n = ST_SET_HR;
            default:    n = s;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] mask_of(input logic [1:0] f);
        logic [7:0] m;
        case (f)
            FIELD_HR:  m = MASK_HR;
            FIELD_MIN: m = MASK_MIN;
            FIELD_SEC: m = MASK_SEC;
            default:   m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/clock_set_controller_debouncer.sv
// key_debouncer: 2-flop synchronizer, consecutive-sample debouncer and a
// registered one-cycle pulse on each accepted 1->0 transition.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[0], raw_i};
        level_d = level_q;
        cnt_d   = '0;
        // Counter only runs while the sample disagrees with the accepted level
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= {2{RESET_LEVEL}};
            level_q <= RESET_LEVEL;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/clock_set_controller.sv
// RUN/SET field sequencer for the 8-digit clock: inc/dec pulses, run gating, blink mask.
// Optional AUTO_REPEAT_EN macro enables hold-to-repeat on the inc/dec keys.
module clock_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = 500000,
    parameter int unsigned BLINK_HALF_CYCLES    = 12500000,
    parameter int unsigned REPEAT_DELAY_CYCLES  = 25000000,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic       clk_50mhz_i,
    input  logic       master_nreset_switch_i,
    input  logic       key1_i,
    input  logic       key2_i,
    input  logic       key3_i,
    input  logic       set_switch_i,
    output logic       run_en_o,
    output logic       set_mode_o,
    output logic [1:0] field_sel_o,
    output logic       inc_pulse_o,
    output logic       dec_pulse_o,
    output logic       clear_sub_o,
    output logic [7:0] blank_mask_o
);

    localparam int unsigned BLK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF_CYCLES - 1);

    logic k1_lvl, k1_press, k2_lvl, k2_press, k3_lvl, k3_press, sw_lvl, sw_fall;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_key1 (
        .clk_i(clk_50mhz_i), .rst_ni(master_nreset_switch_i), .raw_i(key1_i),
        .level_o(k1_lvl), .fall_o(k1_press)
    );
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_key2 (
        .clk_i(clk_50mhz_i), .rst_ni(master_nreset_switch_i), .raw_i(key2_i),
        .level_o(k2_lvl), .fall_o(k2_press)
    );
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_key3 (
        .clk_i(clk_50mhz_i), .rst_ni(master_nreset_switch_i), .raw_i(key3_i),
        .level_o(k3_lvl), .fall_o(k3_press)
    );
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_sw (
        .clk_i(clk_50mhz_i), .rst_ni(master_nreset_switch_i), .raw_i(set_switch_i),
        .level_o(sw_lvl), .fall_o(sw_fall)
    );

    state_e           state_q, state_d;
    logic             run_en_q, run_en_d;
    logic             set_mode_q, set_mode_d;
    logic [1:0]       field_q, field_d;
    logic             inc_q, inc_d;
    logic             dec_q, dec_d;
    logic             clear_q, clear_d;
    logic [7:0]       blank_q, blank_d;
    logic             phase_q, phase_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_restart;
    logic             press_issued;
    logic             rpt_inc, rpt_dec;
    logic             unused_sig;

    always_comb begin
        state_d       = state_q;
        inc_d         = 1'b0;
        dec_d         = 1'b0;
        clear_d       = 1'b0;
        blink_restart = 1'b0;
        press_issued  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (sw_lvl) begin
                    state_d       = ST_SET_HR;
                    blink_restart = 1'b1;
                end
            end
            default: begin
                // Priority: exit > field advance > fresh press > auto-repeat
                if (!sw_lvl) begin
                    state_d = ST_RUN;
                    clear_d = 1'b1;
                end else if (k1_press) begin
                    state_d       = next_field(state_q);
                    blink_restart = 1'b1;
                end else if (k2_press || k3_press) begin
                    inc_d        = k2_press & ~k3_press;
                    dec_d        = k3_press & ~k2_press;
                    press_issued = inc_d | dec_d;
                end else begin
                    inc_d = rpt_inc;
                    dec_d = rpt_dec;
                end
                if (inc_d || dec_d) begin
                    blink_restart = 1'b1;
                end
            end
        endcase

        run_en_d   = (state_d == ST_RUN);
        set_mode_d = (state_d != ST_RUN);
        field_d    = field_of(state_d);

        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (state_d == ST_RUN || blink_restart) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
        blank_d = phase_d ? mask_of(field_d) : '0;
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                      REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic             rpt_active_q, rpt_active_d;
    logic             rpt_first_q, rpt_first_d;
    logic             rpt_up_q, rpt_up_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RPT_W-1:0] rpt_limit;
    logic             rpt_held;
    logic             rpt_fire;

    always_comb begin
        rpt_held  = rpt_up_q ? (~k2_lvl & k3_lvl) : (k2_lvl & ~k3_lvl);
        rpt_limit = rpt_first_q ? RPT_W'(REPEAT_DELAY_CYCLES - 1) : RPT_W'(REPEAT_PERIOD_CYCLES - 1);
        rpt_fire  = rpt_active_q && rpt_held && (state_q != ST_RUN) && (rpt_cnt_q == rpt_limit);
        rpt_inc   = rpt_fire & rpt_up_q;
        rpt_dec   = rpt_fire & ~rpt_up_q;

        rpt_active_d = rpt_active_q;
        rpt_first_d  = rpt_first_q;
        rpt_up_d     = rpt_up_q;
        rpt_cnt_d    = rpt_cnt_q + 1'b1;
        if (press_issued) begin
            rpt_active_d = 1'b1;
            rpt_first_d  = 1'b1;
            rpt_up_d     = inc_d;
            rpt_cnt_d    = '0;
        end else if (!rpt_active_q || !rpt_held || state_d != state_q || state_d == ST_RUN) begin
            rpt_active_d = 1'b0;
            rpt_cnt_d    = '0;
        end else if (rpt_fire) begin
            rpt_first_d  = 1'b0;
            rpt_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_50mhz_i or negedge master_nreset_switch_i) begin
        if (!master_nreset_switch_i) begin
            rpt_active_q <= 1'b0;
            rpt_first_q  <= 1'b0;
            rpt_up_q     <= 1'b0;
            rpt_cnt_q    <= '0;
        end else begin
            rpt_active_q <= rpt_active_d;
            rpt_first_q  <= rpt_first_d;
            rpt_up_q     <= rpt_up_d;
            rpt_cnt_q    <= rpt_cnt_d;
        end
    end

    assign unused_sig = ^{k1_lvl, sw_fall};
`else
    assign rpt_inc    = 1'b0;
    assign rpt_dec    = 1'b0;
    assign unused_sig = ^{k1_lvl, sw_fall, k2_lvl, k3_lvl, press_issued,
                          REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES};
`endif

    always_ff @(posedge clk_50mhz_i or negedge master_nreset_switch_i) begin
        if (!master_nreset_switch_i) begin
            state_q     <= ST_RUN;
            run_en_q    <= 1'b1;
            set_mode_q  <= 1'b0;
            field_q     <= FIELD_NONE;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            clear_q     <= 1'b0;
            blank_q     <= '0;
            phase_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            run_en_q    <= run_en_d;
            set_mode_q  <= set_mode_d;
            field_q     <= field_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            clear_q     <= clear_d;
            blank_q     <= blank_d;
            phase_q     <= phase_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign run_en_o     = run_en_q;
    assign set_mode_o   = set_mode_q;
    assign field_sel_o  = field_q;
    assign inc_pulse_o  = inc_q;
    assign dec_pulse_o  = dec_q;
    assign clear_sub_o  = clear_q;
    assign blank_mask_o = blank_q;

endmodule
